// File: rtl/sensor_sampler.sv
// Duty-cycled sensor sampling controller: windows the sensor enable, captures one
// alert-tagged sample per period and buffers it in a first-word-fall-through FIFO.
module sensor_sampler #(
  parameter int unsigned INTERVAL = 100,
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  THRESH   = 8'd128,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  output logic                     sensor_en,
  input  logic [7:0]               sensor_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_alert,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int unsigned IW = $clog2(INTERVAL + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [IW-1:0] INT_LAST  = IW'(INTERVAL - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARM    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   icnt_r, icnt_s;
  logic [SW-1:0]   scnt_r, scnt_s;
  logic            sen_r, sen_s;
  logic            push_s;

  logic [8:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_s;
  logic            valid_r;
  logic [8:0]      head_r, head_s;
  logic            ovf_r;

  logic            full_s, pop_s, wr_en_s, drop_s;
  logic [8:0]      wdata_s;
  logic [AW-1:0]   rd_nxt_s;

  // Sampling FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Window sequencing: interval count, settle count, enable and capture strobe.
  always_comb begin
    state_s = state_r;
    icnt_s  = icnt_r;
    scnt_s  = scnt_r;
    sen_s   = sen_r;
    push_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) begin
          if (icnt_r == INT_LAST) begin
            icnt_s  = {IW{1'b0}};
            scnt_s  = {SW{1'b0}};
            sen_s   = 1'b1;
            state_s = WARM;
          end else begin
            icnt_s = icnt_r + IW'(1);
          end
        end else begin
          icnt_s = {IW{1'b0}};
        end
      end
      WARM: begin
        if (scnt_r == SET_LAST) begin
          scnt_s  = {SW{1'b0}};
          state_s = CAPTURE;
        end else begin
          scnt_s = scnt_r + SW'(1);
        end
      end
      CAPTURE: begin
        // The window always completes even if run has dropped meanwhile.
        push_s  = 1'b1;
        sen_s   = 1'b0;
        icnt_s  = {IW{1'b0}};
        state_s = IDLE;
      end
      default: begin
        icnt_s  = {IW{1'b0}};
        scnt_s  = {SW{1'b0}};
        sen_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Counters and the sensor enable are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_r <= {IW{1'b0}};
      scnt_r <= {SW{1'b0}};
      sen_r  <= 1'b0;
    end else begin
      icnt_r <= icnt_s;
      scnt_r <= scnt_s;
      sen_r  <= sen_s;
    end
  end

  assign full_s   = (count_r == DEPTH_C);
  assign pop_s    = valid_r & out_ready;
  assign wr_en_s  = push_s & (~full_s | pop_s);
  assign drop_s   = push_s & full_s & ~pop_s;
  assign wdata_s  = {(sensor_data >= THRESH), sensor_data};
  assign rd_nxt_s = rd_ptr_r + AW'(1);

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Next head entry; a sample pushed alongside the last pop becomes the head.
  always_comb begin
    head_s = head_r;
    if (pop_s) begin
      if (count_r > CNT_ONE) begin
        head_s = mem_r[rd_nxt_s];
      end else if (wr_en_s) begin
        head_s = wdata_s;
      end else begin
        head_s = head_r;
      end
    end else if ((count_r == CNT_ZERO) && wr_en_s) begin
      head_s = wdata_s;
    end else begin
      head_s = head_r;
    end
  end

  // FIFO storage, pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= 9'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= 9'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= wdata_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_nxt_s;
      end
      count_r <= count_s;
      valid_r <= (count_s != CNT_ZERO);
      head_r  <= head_s;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (clr_overflow) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign sensor_en  = sen_r;
  assign out_valid  = valid_r;
  assign out_data   = head_r[7:0];
  assign out_alert  = head_r[8];
  assign fifo_count = count_r;
  assign overflow   = ovf_r;

endmodule
